// File: rtl/mux_rr_arbiter_pkg.sv
// mux_rr_arbiter_pkg: shared constants and FSM encoding for the round-robin arbiter
package mux_rr_arbiter_pkg;
    localparam int N_REQ = 4;
    localparam int SEL_W = 2;
    typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;
endpackage

// File: rtl/mux_rr_arbiter_if.sv
// mux_rr_arbiter_if: request/data bundle between requesters and the arbiter
interface mux_rr_arbiter_if #(parameter int DATA_W = 1);
    import mux_rr_arbiter_pkg::*;
    logic [N_REQ-1:0]        req;
    logic [N_REQ*DATA_W-1:0] in_data;
    logic [N_REQ-1:0]        gnt;
    logic [SEL_W-1:0]        sel;
    logic [DATA_W-1:0]       out_data;
    logic                    out_valid;
    modport master (output req, output in_data, input gnt, input sel, input out_data, input out_valid);
    modport slave (input req, input in_data, output gnt, output sel, output out_data, output out_valid);
endinterface

// File: rtl/mux_rr_arbiter_rr_priority_pick.sv
// rr_priority_pick: first set request scanning upward from ptr, wrapping modulo N_REQ
module rr_priority_pick
    import mux_rr_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             any,
    output logic [SEL_W-1:0] idx
);
    assign any = |req;
    // Scan offsets from farthest to nearest so the nearest set bit after ptr wins
    always_comb begin
        idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--)
            if (req[ptr + SEL_W'(k)]) idx = ptr + SEL_W'(k);
    end
endmodule

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin owner of a 4:1 mux with bounded grant length
module mux_rr_arbiter
    import mux_rr_arbiter_pkg::*;
#(
    parameter int DATA_W   = 1,
    parameter int MAX_HOLD = 8
)
(
    input logic             clk,
    input logic             rst_n,
    mux_rr_arbiter_if.slave bus
);
    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    state_t            state;
    logic [SEL_W-1:0]  ptr, sel, pick_idx;
    logic [HOLD_W-1:0] hold_cnt;
    logic [N_REQ-1:0]  gnt;
    logic [DATA_W-1:0] out_data, lane;
    logic              out_valid, pick_any, owner_req;

    rr_priority_pick u_pick (.req(bus.req), .ptr(ptr), .any(pick_any), .idx(pick_idx));

    assign owner_req     = (state == ST_BUSY) && bus.req[sel];
    assign lane          = bus.in_data[sel*DATA_W +: DATA_W];
    assign bus.gnt       = gnt;
    assign bus.sel       = sel;
    assign bus.out_data  = out_data;
    assign bus.out_valid = out_valid;

    // Grant FSM, hold counter and registered data path; owner released on drop or hold limit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            sel       <= '0;
            hold_cnt  <= '0;
            gnt       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= owner_req;
            out_data  <= owner_req ? lane : '0;
            if (state == ST_IDLE) begin
                if (pick_any) begin
                    state    <= ST_BUSY;
                    gnt      <= N_REQ'(1) << pick_idx;
                    sel      <= pick_idx;
                    hold_cnt <= '0;
                end
            end else if (!bus.req[sel] || hold_cnt == HOLD_LAST) begin
                state <= ST_IDLE;
                gnt   <= '0;
                ptr   <= sel + 1'b1;
            end else begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end
endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
- Round-robin arbiter that shares one 4:1 selection datapath among 4 requesters.
- Grants one requester at a time and drives the 2-bit select. Captures the selected lane into a registered output.
- Limits each grant to MAX_HOLD cycles so that no requester starves.
- Sits in front of the team's 4:1 mux; it is the sequencing and ownership layer for that mux.

Parameters:
- DATA_W, 1, width of each requester data lane.
- MAX_HOLD, 8, maximum consecutive cycles one grant may last (legal range 1..256).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  request per requester; bit i belongs to requester i.
- in_data  input  4*DATA_W  lane i = in_data[i*DATA_W +: DATA_W].
- gnt  output  4  one-hot grant, registered; 0 when idle.
- sel  output  2  registered mux select; equals the index of the granted requester.
- out_data  output  DATA_W  registered selected lane.
- out_valid  output  1  out_data holds valid data from a requester that is granted and still requesting.

Behaviour:
- All state and outputs use one clock. Reset is asynchronous, active-low (rst_n), and clears immediately, including mid-grant.
- Reset values: gnt=0, sel=0, out_data=0, out_valid=0, busy=0, ptr=0, hold_cnt=0.
- Internal state:
  - busy: 1 bit; IDLE=0, BUSY=1.
  - ptr: 2 bits; the highest-priority index.
  - hold_cnt: max(1, clog2(MAX_HOLD)) bits.
- IDLE:
  - req==0: stay in IDLE; gnt=0.
  - Otherwise pick the first set bit scanning ptr, ptr+1, ... modulo 4.
  - Next edge: busy=1, gnt=onehot(pick), sel=pick, hold_cnt=0.
  - Latency from req to gnt is 1 cycle.
- BUSY, evaluated at each edge using pre-edge values:
  - Release condition: req[sel]==0, or hold_cnt==MAX_HOLD-1.
  - On release: busy=0, gnt=0, ptr=sel+1 (3 wraps to 0); sel keeps its value.
  - Otherwise: hold_cnt+1; gnt and sel unchanged.
  - Requests from other requesters never pre-empt an active grant.
- Turnaround: after every release, gnt is 0 for exactly one cycle (IDLE). Arbitration then uses the updated ptr.
- Data path, every edge:
  - out_valid <= busy & req[sel].
  - out_data <= (busy & req[sel]) ? lane[sel] : 0.
  - Data therefore lags gnt by one cycle.
- With MAX_HOLD=N and req held continuously: gnt is high for exactly N cycles, out_valid for exactly N cycles shifted by +1.
- MAX_HOLD=1: every grant lasts 1 cycle; continuous requesters alternate grant/idle.
- Simultaneous release and new requests: the new requests are considered only in the following IDLE cycle.
- A requester that drops req while granted loses the grant at the next edge; it must re-request and wait its turn.
- Invariants: gnt is always one-hot or zero; gnt!=0 exactly when busy==1; gnt[sel]==1 whenever busy.

Decomposition:
- Shared include/package: N_REQ=4, SEL_W=2, state encodings ST_IDLE=1'b0 and ST_BUSY=1'b1.
- One sub-module is natural: rr_priority_pick.
  - Purely combinational.
  - Inputs: req[3:0], ptr[1:0].
  - Outputs: any, idx[1:0].
  - It rotates req by ptr, finds the lowest set bit, and rotates the index back.
- The top level holds the FSM, hold counter and output registers.

Test Plan:
- Reset/idle: rst_n=0 then 1, req=0 for 10 cycles -> gnt=0, sel=0, out_valid=0 throughout.
- Single requester: MAX_HOLD=8, req=4'b0100 held, lane2=1.
  - gnt=4'b0100 from cycle 1 to cycle 8; cycle 9 gnt=0; cycle 10 regranted.
  - out_valid high cycles 2-9 with out_data=1.
- Round-robin fairness: req=4'b1111 held, MAX_HOLD=2.
  - Grant order 0,1,2,3,0; each grant lasts 2 cycles, separated by 1 idle cycle.
  - Check the ptr wrap 3->0.
- Early release/no pre-emption: requester 1 granted; req[3] rises mid-grant; req[1] drops after 3 cycles.
  - gnt stays 4'b0010 until req[1] drops.
  - Then 1 idle cycle, then gnt=4'b1000.
- Priority rotation: after requester 3 releases, req=4'b0011 -> grant goes to requester 0 (ptr=0). After requester 0 releases -> requester 1.
- Async reset mid-grant: drop rst_n between clock edges while gnt=4'b0100.
  - gnt, out_valid and sel clear immediately, without waiting for a clock edge.
  - After release, req=4'b0100 -> grant again from ptr=0.
